spi_response_controller: RTL and testbench

SPI_RESPONSE_CONTROLLER -- requirements
Module: spi_response_controller

---
 rtl/spi_cmd_pkg.sv | 40 ++++
 rtl/spi_response_controller.sv | 214 +++++++++++++++++++++
 tb/tb_spi_response_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared SPI command opcodes and the response-path state encoding.
// SPI_RESP_CHECKSUM_EN adds the trailing checksum state.
package spi_cmd_pkg;

  localparam logic [7:0] CmdLoadA      = 8'h01;
  localparam logic [7:0] CmdLoadB      = 8'h02;
  localparam logic [7:0] CmdStart      = 8'h03;
  localparam logic [7:0] CmdReadResult = 8'h04;
  localparam logic [7:0] CmdReadStatus = 8'h05;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StSkip,
    StRdReq,
    StRdWait,
    StSendHi,
    StSendLo,
    StSendStat
`ifdef SPI_RESP_CHECKSUM_EN
    ,
    StSendCsum
`endif
  } resp_state_e;

  // States in which a byte is presented to the SPI shifter.
  function automatic logic is_tx_state(input resp_state_e s);
    logic r;
    r = 1'b0;
    case (s)
      StSendHi, StSendLo, StSendStat: r = 1'b1;
`ifdef SPI_RESP_CHECKSUM_EN
      StSendCsum:                     r = 1'b1;
`endif
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_response_controller.sv
// Read-side SPI command controller: streams result-RAM words or a status byte to the shifter.
// Define SPI_RESP_CHECKSUM_EN to append an XOR checksum byte after READ_RESULT payload.
module spi_response_controller
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            spi_data,
  input  logic                  spi_byte_ready,
  input  logic                  matmul_busy,
  input  logic                  matmul_done,
  output logic                  res_rd_en,
  output logic [ADDR_WIDTH-1:0] res_rd_addr,
  input  logic [DATA_WIDTH-1:0] res_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned AddrHiW = ADDR_WIDTH - 8;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

  resp_state_e           state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [1:0]            hdr_idx_q, hdr_idx_d;
  logic [AddrHiW-1:0]    addr_h_q, addr_h_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_h_q, len_h_d;
  logic [15:0]           len_q, len_d;
  logic [16:0]           skip_q, skip_d;
  logic [7:0]            word_lo_q, word_lo_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [15:0]           len_new;
`ifdef SPI_RESP_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            csum_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_read_q <= 1'b0;
      hdr_idx_q <= '0;
      addr_h_q  <= '0;
      addr_q    <= '0;
      len_h_q   <= '0;
      len_q     <= '0;
      skip_q    <= '0;
      word_lo_q <= '0;
      tx_data_q <= '0;
`ifdef SPI_RESP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      hdr_idx_q <= hdr_idx_d;
      addr_h_q  <= addr_h_d;
      addr_q    <= addr_d;
      len_h_q   <= len_h_d;
      len_q     <= len_d;
      skip_q    <= skip_d;
      word_lo_q <= word_lo_d;
      tx_data_q <= tx_data_d;
`ifdef SPI_RESP_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    hdr_idx_d = hdr_idx_q;
    addr_h_d  = addr_h_q;
    addr_d    = addr_q;
    len_h_d   = len_h_q;
    len_d     = len_q;
    skip_d    = skip_q;
    word_lo_d = word_lo_q;
    tx_data_d = tx_data_q;
    len_new   = {len_h_q, spi_data};
`ifdef SPI_RESP_CHECKSUM_EN
    csum_d    = csum_q;
    csum_next = csum_q ^ tx_data_q;
`endif

    case (state_q)
      StIdle: begin
        if (spi_byte_ready) begin
          case (spi_data)
            CmdLoadA, CmdLoadB: begin
              state_d   = StHdr;
              is_read_d = 1'b0;
              hdr_idx_d = '0;
            end
            CmdReadResult: begin
              state_d   = StHdr;
              is_read_d = 1'b1;
              hdr_idx_d = '0;
`ifdef SPI_RESP_CHECKSUM_EN
              csum_d    = '0;
`endif
            end
            CmdReadStatus: begin
              state_d   = StSendStat;
              tx_data_d = {matmul_busy, matmul_done, 6'b0};
            end
            CmdStart: state_d = StIdle;
            default:  state_d = StIdle;
          endcase
        end
      end

      // Header order: addr_h, addr_l, len_h, len_l.
      StHdr: begin
        if (spi_byte_ready) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd0: addr_h_d = spi_data[AddrHiW-1:0];
            2'd1: addr_d   = {addr_h_q, spi_data};
            2'd2: len_h_d  = spi_data;
            default: begin
              len_d = len_new;
              if (!is_read_q) begin
                if (len_new == 16'd0) begin
                  state_d = StIdle;
                end else begin
                  state_d = StSkip;
                  skip_d  = {len_new, 1'b0};
                end
              end else if (len_new == 16'd0) begin
`ifdef SPI_RESP_CHECKSUM_EN
                state_d   = StSendCsum;
                tx_data_d = csum_q;
`else
                state_d   = StIdle;
`endif
              end else begin
                state_d = StRdReq;
              end
            end
          endcase
        end
      end

      StSkip: begin
        if (spi_byte_ready) begin
          skip_d = skip_q - 17'd1;
          if (skip_q == 17'd1) state_d = StIdle;
        end
      end

      StRdReq: state_d = StRdWait;

      StRdWait: begin
        tx_data_d = res_rd_data[15:8];
        word_lo_d = res_rd_data[7:0];
        state_d   = StSendHi;
      end

      StSendHi: begin
        if (tx_ready) begin
`ifdef SPI_RESP_CHECKSUM_EN
          csum_d    = csum_next;
`endif
          tx_data_d = word_lo_q;
          state_d   = StSendLo;
        end
      end

      StSendLo: begin
        if (tx_ready) begin
          len_d  = len_q - 16'd1;
          addr_d = addr_q + AddrOne;
`ifdef SPI_RESP_CHECKSUM_EN
          csum_d = csum_next;
`endif
          if (len_q == 16'd1) begin
`ifdef SPI_RESP_CHECKSUM_EN
            state_d   = StSendCsum;
            tx_data_d = csum_next;
`else
            state_d   = StIdle;
`endif
          end else begin
            state_d = StRdReq;
          end
        end
      end

      StSendStat: begin
        if (tx_ready) state_d = StIdle;
      end

`ifdef SPI_RESP_CHECKSUM_EN
      StSendCsum: begin
        if (tx_ready) state_d = StIdle;
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  assign res_rd_en   = (state_q == StRdReq);
  assign res_rd_addr = addr_q;
  assign tx_valid    = is_tx_state(state_q);
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_spi_response_controller.sv
// Bench for spi_response_controller: table of command streams with a tx/read-address scoreboard.
module tb_spi_response_controller;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    spi_data;
  logic          spi_byte_ready;
  logic          matmul_busy;
  logic          matmul_done;
  logic          res_rd_en;
  logic [AW-1:0] res_rd_addr;
  logic [15:0]   res_rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  spi_response_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_data       (spi_data),
    .spi_byte_ready (spi_byte_ready),
    .matmul_busy    (matmul_busy),
    .matmul_done    (matmul_done),
    .res_rd_en      (res_rd_en),
    .res_rd_addr    (res_rd_addr),
    .res_rd_data    (res_rd_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:7][7:0]  rx;
    logic [3:0]       n_rx;
    logic [4:0]       stall;
    logic             busy;
    logic             done;
    logic             is_read;
    logic [0:3][7:0]  exp;
    logic [2:0]       n_exp;
    logic [0:1][15:0] rd;
    logic [1:0]       n_rd;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] rd_q[$];
  int          rd_cnt = 0;
  int          stall = 0;
  logic        manual = 1'b0;
  logic        man_ready = 1'b0;
  int          wcnt = 0;
  logic [15:0] mem [0:(1<<AW)-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Result RAM with one-cycle read latency.
  always @(posedge clk) if (res_rd_en) res_rd_data <= mem[res_rd_addr];

  // tx_ready: always high, or held low for `stall` cycles per offered byte, or manual.
  always @(posedge clk) begin
    #1;
    if (manual) tx_ready = man_ready;
    else if (stall == 0) tx_ready = 1'b1;
    else if (tx_valid) begin
      if (wcnt >= stall) begin
        tx_ready = 1'b1;
        wcnt = 0;
      end else begin
        tx_ready = 1'b0;
        wcnt++;
      end
    end else begin
      tx_ready = 1'b0;
      wcnt = 0;
    end
  end

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (tx_valid && prev_valid && !prev_ready) check("tx_hold", {24'h0, tx_data}, {24'h0, prev_data});
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
      if (res_rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) check("rd_unexpected", {22'h0, res_rd_addr}, 32'hFFFF_FFFF);
        else check("rd_addr", {22'h0, res_rd_addr}, {16'h0, rd_q.pop_front()});
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    spi_data = b;
    spi_byte_ready = 1'b1;
    @(posedge clk);
    #1;
    spi_byte_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [7:0] cs;
    int budget;
    stall = int'(v.stall);
    matmul_busy = v.busy;
    matmul_done = v.done;
    rd_cnt = 0;
    cs = 8'h00;
    for (int i = 0; i < int'(v.n_exp); i++) begin
      tx_q.push_back(v.exp[i]);
      cs ^= v.exp[i];
    end
`ifdef SPI_RESP_CHECKSUM_EN
    if (v.is_read) tx_q.push_back(cs);
`endif
    for (int i = 0; i < int'(v.n_rd); i++) rd_q.push_back(v.rd[i]);
    for (int i = 0; i < int'(v.n_rx); i++) send_byte(v.rx[i]);
    budget = 0;
    while ((tx_q.size() != 0 || rd_q.size() != 0) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    repeat (10) @(negedge clk);
    check({name, "_tx_left"}, tx_q.size(), 0);
    check({name, "_rd_left"}, rd_q.size(), 0);
    check({name, "_rd_cnt"}, rd_cnt, {30'h0, v.n_rd});
    tx_q.delete();
    rd_q.delete();
  endtask

  vec_t vecs[8];
  vec_t v_stat;

  initial begin
    int budget;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 3 + 16'h0100);
    mem[10'h010] = 16'hA1B2;
    mem[10'h011] = 16'hC3D4;
    mem[10'h3FF] = 16'h1234;
    mem[10'h000] = 16'h5678;

    vecs[0] = '{rx: {8'h04, 8'h00, 8'h10, 8'h00, 8'h02, 24'h0}, n_rx: 4'd5, stall: 5'd0,
                busy: 1'b0, done: 1'b0, is_read: 1'b1, exp: 32'hA1B2_C3D4, n_exp: 3'd4,
                rd: {16'h0010, 16'h0011}, n_rd: 2'd2};
    vecs[1] = vecs[0];
    vecs[1].stall = 5'd5;
    vecs[2] = '{rx: {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h05, 8'h05}, n_rx: 4'd8,
                stall: 5'd0, busy: 1'b0, done: 1'b1, is_read: 1'b0, exp: 32'h4000_0000,
                n_exp: 3'd1, rd: 32'h0, n_rd: 2'd0};
    vecs[3] = '{rx: {8'h04, 8'h03, 8'hFF, 8'h00, 8'h02, 24'h0}, n_rx: 4'd5, stall: 5'd0,
                busy: 1'b0, done: 1'b0, is_read: 1'b1, exp: 32'h1234_5678, n_exp: 3'd4,
                rd: {16'h03FF, 16'h0000}, n_rd: 2'd2};
    vecs[4] = '{rx: {8'h04, 8'h00, 8'h10, 8'h00, 8'h00, 24'h0}, n_rx: 4'd5, stall: 5'd0,
                busy: 1'b0, done: 1'b0, is_read: 1'b1, exp: 32'h0, n_exp: 3'd0,
                rd: 32'h0, n_rd: 2'd0};
    vecs[5] = '{rx: {8'h03, 8'h07, 8'h05, 40'h0}, n_rx: 4'd3, stall: 5'd0,
                busy: 1'b1, done: 1'b0, is_read: 1'b0, exp: 32'h8000_0000, n_exp: 3'd1,
                rd: 32'h0, n_rd: 2'd0};
    vecs[6] = '{rx: {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 16'h0}, n_rx: 4'd6,
                stall: 5'd0, busy: 1'b1, done: 1'b1, is_read: 1'b0, exp: 32'hC000_0000,
                n_exp: 3'd1, rd: 32'h0, n_rd: 2'd0};
    // Trailing 0x05 lands mid-read and must be discarded.
    vecs[7] = '{rx: {8'h04, 8'h00, 8'h10, 8'h00, 8'h01, 8'h05, 16'h0}, n_rx: 4'd6,
                stall: 5'd0, busy: 1'b1, done: 1'b1, is_read: 1'b1, exp: 32'hA1B2_0000,
                n_exp: 3'd2, rd: {16'h0010, 16'h0000}, n_rd: 2'd1};
    v_stat = '{rx: {8'h05, 56'h0}, n_rx: 4'd1, stall: 5'd0, busy: 1'b0, done: 1'b1,
               is_read: 1'b0, exp: 32'h4000_0000, n_exp: 3'd1, rd: 32'h0, n_rd: 2'd0};

    rst_n = 1'b0;
    spi_data = 8'h00;
    spi_byte_ready = 1'b0;
    matmul_busy = 1'b0;
    matmul_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rd_en", {31'h0, res_rd_en}, 32'h0);
    check("rst_rd_addr", {22'h0, res_rd_addr}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the low byte is being offered.
    manual = 1'b1;
    man_ready = 1'b0;
    tx_q.push_back(8'hA1);
    rd_q.push_back(16'h0010);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h02);
    budget = 0;
    while (!tx_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("abort_hi_valid", {31'h0, tx_valid}, 32'h1);
    man_ready = 1'b1;
    @(posedge clk);
    #2 man_ready = 1'b0;
    @(posedge clk);
    #3;
    check("abort_lo_valid", {31'h0, tx_valid}, 32'h1);
    check("abort_lo_data", {24'h0, tx_data}, 32'h0000_00B2);
    check("abort_tx_left", tx_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("abort_rst_data", {24'h0, tx_data}, 32'h0);
    check("abort_rst_addr", {22'h0, res_rd_addr}, 32'h0);
    tx_q.delete();
    rd_q.delete();
    #10 rst_n = 1'b1;
    manual = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(v_stat, "post_abort_stat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
